rpn_lan_to_network_bridge_merger: RTL and testbench

//  Egress counterpart of the RPN LAN from-network-bridge splitter. Merges three RPN LAN AXIS sources into the

---
 rtl/rpn_lan_merger_pkg.sv | 34 +++
 rtl/rpn_axis_skid_buffer.sv | 63 ++++++
 rtl/rpn_lan_to_network_bridge_merger.sv | 172 +++++++++++++++++
 tb/tb_rpn_lan_to_network_bridge_merger.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_lan_merger_pkg.sv
// Shared types and constants for the RPN LAN to network-bridge merger.
// Source indices, the arbiter state enum and the packed beat used for muxing/buffering.
package rpn_lan_merger_pkg;

  localparam int AXIS_DATA_W  = 512;
  localparam int AXIS_KEEP_W  = AXIS_DATA_W / 8;
  localparam int AXIS_TDEST_W = 16;
  localparam int AXIS_TUSER_W = 16;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] SRC_SEQ_INIT = 2'd0;
  localparam logic [1:0] SRC_TX       = 2'd1;
  localparam logic [1:0] SRC_RX       = 2'd2;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0]  tdata;
    logic [AXIS_KEEP_W-1:0]  tkeep;
    logic [AXIS_TDEST_W-1:0] tid;
    logic [AXIS_TDEST_W-1:0] tdest;
    logic [AXIS_TUSER_W-1:0] tuser;
    logic                    tlast;
  } rpn_axis_beat_t;

  function automatic logic [1:0] rr_next(input logic [1:0] src);
    return (src == SRC_RX) ? SRC_SEQ_INIT : src + 2'd1;
  endfunction

endpackage

// File: rtl/rpn_axis_skid_buffer.sv
// Generic 2-entry AXIS skid buffer: registered outputs, full throughput,
// upstream ready is simply "skid slot empty". Synchronous active-high reset empties it.
module rpn_axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             push;

  assign s_ready_o = ~skid_valid_q;
  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;
  assign push      = s_valid_i & ~skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || m_ready_i) begin
      // output slot frees up: refill from skid first to keep beat order
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_data_d = s_data_i;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/rpn_lan_to_network_bridge_merger.sv
// Packet-atomic round-robin merge of seq-num init, LAN TX and LAN RX AXIS into the network-bridge stream.
// RPN_LAN_TO_NB_MERGER_REG_OUT_EN: registers the output through a 2-entry skid buffer (latency 1).
//   state      | meaning
//   ARB_OPEN   | no packet in flight, grant picked round-robin from rr_ptr each cycle
//   ARB_LOCKED | packet (or stalled beat) in flight, grant held until its tlast transfers
module rpn_lan_to_network_bridge_merger
  import rpn_lan_merger_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH        = AXIS_DATA_W,
  parameter int AXIS_KEEP_WIDTH        = AXIS_KEEP_W,
  parameter int AXIS_TO_NB_TDEST_WIDTH = AXIS_TDEST_W,
  parameter int AXIS_TO_NB_TUSER_WIDTH = AXIS_TUSER_W
) (
  input  logic                              i_clk,
  input  logic                              i_ap_rst,

  input  logic                              from_rpn_LAN_seq_num_init_tvalid,
  output logic                              from_rpn_LAN_seq_num_init_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_LAN_seq_num_init_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_LAN_seq_num_init_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_seq_num_init_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_seq_num_init_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_LAN_seq_num_init_tuser,
  input  logic                              from_rpn_LAN_seq_num_init_tlast,

  input  logic                              from_rpn_LAN_TX_tvalid,
  output logic                              from_rpn_LAN_TX_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_LAN_TX_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_LAN_TX_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_TX_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_TX_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_LAN_TX_tuser,
  input  logic                              from_rpn_LAN_TX_tlast,

  input  logic                              from_rpn_LAN_RX_tvalid,
  output logic                              from_rpn_LAN_RX_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_LAN_RX_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_LAN_RX_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_RX_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_RX_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_LAN_RX_tuser,
  input  logic                              from_rpn_LAN_RX_tlast,

  output logic                              to_network_bridge_tvalid,
  input  logic                              to_network_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]        to_network_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]        to_network_bridge_tkeep,
  output logic [AXIS_TO_NB_TDEST_WIDTH-1:0] to_network_bridge_tid,
  output logic [AXIS_TO_NB_TDEST_WIDTH-1:0] to_network_bridge_tdest,
  output logic [AXIS_TO_NB_TUSER_WIDTH-1:0] to_network_bridge_tuser,
  output logic                              to_network_bridge_tlast
);

  arb_state_e     state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic [1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC-1:0] src_ready;
  rpn_axis_beat_t     src_beat [NUM_SRC];

  logic [1:0]     grant, scan1, scan2;
  logic           grant_vld;
  logic           arb_valid, arb_ready, arb_xfer;
  rpn_axis_beat_t arb_beat;
  logic           out_valid;
  rpn_axis_beat_t out_beat;

  assign src_valid = {from_rpn_LAN_RX_tvalid, from_rpn_LAN_TX_tvalid, from_rpn_LAN_seq_num_init_tvalid};

  assign src_beat[SRC_SEQ_INIT] = '{tdata: from_rpn_LAN_seq_num_init_tdata, tkeep: from_rpn_LAN_seq_num_init_tkeep,
                                    tid: from_rpn_LAN_seq_num_init_tid, tdest: from_rpn_LAN_seq_num_init_tdest,
                                    tuser: from_rpn_LAN_seq_num_init_tuser, tlast: from_rpn_LAN_seq_num_init_tlast};
  assign src_beat[SRC_TX]       = '{tdata: from_rpn_LAN_TX_tdata, tkeep: from_rpn_LAN_TX_tkeep,
                                    tid: from_rpn_LAN_TX_tid, tdest: from_rpn_LAN_TX_tdest,
                                    tuser: from_rpn_LAN_TX_tuser, tlast: from_rpn_LAN_TX_tlast};
  assign src_beat[SRC_RX]       = '{tdata: from_rpn_LAN_RX_tdata, tkeep: from_rpn_LAN_RX_tkeep,
                                    tid: from_rpn_LAN_RX_tid, tdest: from_rpn_LAN_RX_tdest,
                                    tuser: from_rpn_LAN_RX_tuser, tlast: from_rpn_LAN_RX_tlast};

  always_comb begin
    scan1     = rr_next(rr_ptr_q);
    scan2     = rr_next(scan1);
    grant_vld = 1'b0;
    grant     = rr_ptr_q;
    if (state_q == ARB_LOCKED) begin
      grant_vld = 1'b1;
      grant     = grant_q;
    end else if (src_valid[rr_ptr_q]) begin
      grant_vld = 1'b1;
      grant     = rr_ptr_q;
    end else if (src_valid[scan1]) begin
      grant_vld = 1'b1;
      grant     = scan1;
    end else if (src_valid[scan2]) begin
      grant_vld = 1'b1;
      grant     = scan2;
    end
  end

  assign arb_valid = ~i_ap_rst & grant_vld & src_valid[grant];
  assign arb_beat  = src_beat[grant];
  assign arb_xfer  = arb_valid & arb_ready;

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      src_ready[k] = ~i_ap_rst & grant_vld & (grant == 2'(k)) & arb_ready;
    end
  end

  assign from_rpn_LAN_seq_num_init_tready = src_ready[SRC_SEQ_INIT];
  assign from_rpn_LAN_TX_tready           = src_ready[SRC_TX];
  assign from_rpn_LAN_RX_tready           = src_ready[SRC_RX];

  // any visible beat that is not a completed tlast pins the grant, keeping tvalid/tdata stable
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (arb_xfer && arb_beat.tlast) begin
      state_d  = ARB_OPEN;
      rr_ptr_d = rr_next(grant);
    end else if (arb_valid) begin
      state_d = ARB_LOCKED;
      grant_d = grant;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      state_q  <= ARB_OPEN;
      grant_q  <= SRC_SEQ_INIT;
      rr_ptr_q <= SRC_SEQ_INIT;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef RPN_LAN_TO_NB_MERGER_REG_OUT_EN
  logic [$bits(rpn_axis_beat_t)-1:0] out_beat_vec;

  rpn_axis_skid_buffer #(
    .WIDTH($bits(rpn_axis_beat_t))
  ) u_out_skid (
    .clk_i    (i_clk),
    .rst_i    (i_ap_rst),
    .s_valid_i(arb_valid),
    .s_ready_o(arb_ready),
    .s_data_i (arb_beat),
    .m_valid_o(out_valid),
    .m_ready_i(to_network_bridge_tready),
    .m_data_o (out_beat_vec)
  );

  assign out_beat = rpn_axis_beat_t'(out_beat_vec);
`else
  assign arb_ready = to_network_bridge_tready;
  assign out_valid = arb_valid;
  assign out_beat  = arb_beat;
`endif

  assign to_network_bridge_tvalid = out_valid & ~i_ap_rst;
  assign to_network_bridge_tdata  = out_beat.tdata;
  assign to_network_bridge_tkeep  = out_beat.tkeep;
  assign to_network_bridge_tid    = out_beat.tid;
  assign to_network_bridge_tdest  = out_beat.tdest;
  assign to_network_bridge_tuser  = out_beat.tuser;
  assign to_network_bridge_tlast  = out_beat.tlast;

endmodule

// File: tb/tb_rpn_lan_to_network_bridge_merger.sv
// Self-checking bench for rpn_lan_to_network_bridge_merger; packet-level round-robin reference model.
// Works with or without RPN_LAN_TO_NB_MERGER_REG_OUT_EN (output latency adjusts by LAT).
module tb_rpn_lan_to_network_bridge_merger;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int TW = 16;
  localparam int UW = 16;
`ifdef RPN_LAN_TO_NB_MERGER_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [TW-1:0] id;
    logic [TW-1:0] dest;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] s_valid;
  logic [2:0] s_ready;
  beat_t      s_beat [3];

  logic          o_valid, o_ready, o_last;
  logic [DW-1:0] o_data;
  logic [KW-1:0] o_keep;
  logic [TW-1:0] o_id, o_dest;
  logic [UW-1:0] o_user;
  beat_t         o_beat;
  assign o_beat = {o_data, o_keep, o_id, o_dest, o_user, o_last};

  rpn_lan_to_network_bridge_merger dut (
    .i_clk                           (clk),
    .i_ap_rst                        (rst),
    .from_rpn_LAN_seq_num_init_tvalid(s_valid[0]),
    .from_rpn_LAN_seq_num_init_tready(s_ready[0]),
    .from_rpn_LAN_seq_num_init_tdata (s_beat[0].data),
    .from_rpn_LAN_seq_num_init_tkeep (s_beat[0].keep),
    .from_rpn_LAN_seq_num_init_tid   (s_beat[0].id),
    .from_rpn_LAN_seq_num_init_tdest (s_beat[0].dest),
    .from_rpn_LAN_seq_num_init_tuser (s_beat[0].user),
    .from_rpn_LAN_seq_num_init_tlast (s_beat[0].last),
    .from_rpn_LAN_TX_tvalid          (s_valid[1]),
    .from_rpn_LAN_TX_tready          (s_ready[1]),
    .from_rpn_LAN_TX_tdata           (s_beat[1].data),
    .from_rpn_LAN_TX_tkeep           (s_beat[1].keep),
    .from_rpn_LAN_TX_tid             (s_beat[1].id),
    .from_rpn_LAN_TX_tdest           (s_beat[1].dest),
    .from_rpn_LAN_TX_tuser           (s_beat[1].user),
    .from_rpn_LAN_TX_tlast           (s_beat[1].last),
    .from_rpn_LAN_RX_tvalid          (s_valid[2]),
    .from_rpn_LAN_RX_tready          (s_ready[2]),
    .from_rpn_LAN_RX_tdata           (s_beat[2].data),
    .from_rpn_LAN_RX_tkeep           (s_beat[2].keep),
    .from_rpn_LAN_RX_tid             (s_beat[2].id),
    .from_rpn_LAN_RX_tdest           (s_beat[2].dest),
    .from_rpn_LAN_RX_tuser           (s_beat[2].user),
    .from_rpn_LAN_RX_tlast           (s_beat[2].last),
    .to_network_bridge_tvalid        (o_valid),
    .to_network_bridge_tready        (o_ready),
    .to_network_bridge_tdata         (o_data),
    .to_network_bridge_tkeep         (o_keep),
    .to_network_bridge_tid           (o_id),
    .to_network_bridge_tdest         (o_dest),
    .to_network_bridge_tuser         (o_user),
    .to_network_bridge_tlast         (o_last)
  );

  int checks = 0;
  int errors = 0;

  beat_t src_q [3][$];
  beat_t mq    [3][$];
  int    plen  [3][$];
  beat_t exp_q [$];
  int    mptr;

  int    gap_cnt [3];
  int    gap_after [3];
  int    gap_len [3];
  int    fired_in_pkt [3];
  int    ready_hold;
  bit    ready_rand;
  bit    sb_en;
  bit    bp_chk;
  bit    gap_watch;
  bit    prev_stall;
  beat_t prev_beat;

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input beat_t obs, input beat_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic beat_t gen_beat(input int k, input bit last);
    beat_t b;
    for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
    b.data[7:0] = (k == 1) ? 8'h00 : 8'(k + 1);
    b.keep = {$urandom(), $urandom()};
    b.id   = 16'($urandom());
    b.dest = 16'($urandom());
    b.user = 16'($urandom());
    b.last = last;
    return b;
  endfunction

  task automatic add_pkt(input int k, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = gen_beat(k, i == len - 1);
      src_q[k].push_back(b);
      mq[k].push_back(b);
    end
    plen[k].push_back(len);
  endtask

  // reference: whole packets, first non-empty source from mptr, mptr moves past the winner
  task automatic model_run();
    int s;
    int len;
    bit found;
    forever begin
      found = 1'b0;
      for (int j = 0; j < 3 && !found; j++) begin
        s = (mptr + j) % 3;
        if (plen[s].size() > 0) begin
          found = 1'b1;
          len = plen[s].pop_front();
          for (int i = 0; i < len; i++) exp_q.push_back(mq[s].pop_front());
          mptr = (s + 1) % 3;
        end
      end
      if (!found) break;
    end
  endtask

  task automatic drive_src();
    for (int k = 0; k < 3; k++) begin
      s_valid[k] = (src_q[k].size() > 0) && (gap_cnt[k] == 0);
      s_beat[k]  = (src_q[k].size() > 0) ? src_q[k][0] : '0;
    end
  endtask

  task automatic drive_ready();
    if (ready_hold > 0) begin
      o_ready = 1'b0;
      ready_hold--;
    end else begin
      o_ready = ready_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
    end
  endtask

  task automatic step();
    logic [2:0] fired;
    beat_t b;
    @(negedge clk);
    fired = s_valid & s_ready;
    chk_int("one_ready", int'($countones(s_ready) <= 1), 1);
    if (prev_stall && !rst) begin
      chk_int("stall_valid", int'(o_valid), 1);
      chk_beat("stall_beat", o_beat, prev_beat);
    end
    if (bp_chk && !o_ready) chk_int("bp_tx_ready", int'(s_ready[1]), 0);
    if (gap_watch && gap_cnt[1] > 0) chk_int("gap_rx_ready", int'(s_ready[2]), 0);
    if (o_valid && o_ready && !rst && sb_en) begin
      if (exp_q.size() == 0) chk_int("unexpected_beat", 1, 0);
      else chk_beat("out_beat", o_beat, exp_q.pop_front());
    end
    prev_stall = o_valid & ~o_ready & ~rst;
    prev_beat  = o_beat;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (fired[k]) begin
        b = src_q[k].pop_front();
        if (b.last) fired_in_pkt[k] = 0;
        else begin
          fired_in_pkt[k]++;
          if (fired_in_pkt[k] == gap_after[k] && gap_len[k] > 0) gap_cnt[k] = gap_len[k];
        end
      end else if (gap_cnt[k] > 0) gap_cnt[k]--;
    end
    drive_src();
    drive_ready();
  endtask

  task automatic run(input string tag, input int budget, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk_int({tag, "_drain"}, exp_q.size(), 0);
    chk_int({tag, "_src_left"}, src_q[0].size() + src_q[1].size() + src_q[2].size(), 0);
  endtask

  task automatic clear_all();
    for (int k = 0; k < 3; k++) begin
      src_q[k].delete();
      mq[k].delete();
      plen[k].delete();
      gap_cnt[k] = 0;
      gap_after[k] = 0;
      gap_len[k] = 0;
      fired_in_pkt[k] = 0;
    end
    exp_q.delete();
    ready_hold = 0;
    ready_rand = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    drive_src();
    drive_ready();
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    mptr = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sb_en = 1'b1;
    bp_chk = 1'b0;
    gap_watch = 1'b0;
    clear_all();

    // reset with every source presenting a beat
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_valid[k] = 1'b1;
      s_beat[k]  = gen_beat(k, 1'b0);
    end
    o_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_int("rst_out_valid", int'(o_valid), 0);
    chk_int("rst_src_ready", int'(s_ready), 0);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk_int("idle_out_valid", int'(o_valid), 0);
    chk_int("idle_src_ready", int'(s_ready), 0);
    @(posedge clk);
    #1;

    // single source: TX 3-beat packet
    do_reset();
    add_pkt(1, 3);
    model_run();
    drive_src();
    drive_ready();
    run("single", 20, n);
    chk_int("single_cycles", n, 3 + LAT);

    // contention: all three 2-beat packets at once
    do_reset();
    for (int k = 0; k < 3; k++) add_pkt(k, 2);
    model_run();
    drive_src();
    drive_ready();
    run("contend", 30, n);
    chk_int("contend_cycles", n, 6 + LAT);

    // backpressure: RX in flight, output stalled 5 cycles, TX waiting
    do_reset();
    add_pkt(2, 3);
    model_run();
    ready_hold = 5;
    bp_chk = 1'b1;
    drive_src();
    drive_ready();
    step();
    add_pkt(1, 2);
    model_run();
    drive_src();
    run("backpressure", 40, n);
    bp_chk = 1'b0;

    // mid-packet gap on TX with RX waiting
    do_reset();
    gap_after[1] = 1;
    gap_len[1]   = 3;
    add_pkt(1, 3);
    add_pkt(2, 1);
    model_run();
    gap_watch = 1'b1;
    drive_src();
    drive_ready();
    run("gap", 30, n);
    gap_watch = 1'b0;
    gap_len[1] = 0;
    chk_int("gap_cycles", n, 7 + LAT);

    // fairness: TX and RX always valid with 1-beat packets
    do_reset();
    for (int i = 0; i < 50; i++) begin
      add_pkt(1, 1);
      add_pkt(2, 1);
    end
    model_run();
    drive_src();
    drive_ready();
    run("fair", 300, n);
    chk_int("fair_cycles", n, 100 + LAT);

    // randomized rounds: random lengths, random output stalls, random mid-packet gaps
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 3; k++) begin
        gap_after[k] = $urandom_range(1, 3);
        gap_len[k]   = $urandom_range(0, 2);
        fired_in_pkt[k] = 0;
        for (int p = 0; p < int'($urandom_range(0, 3)); p++) add_pkt(k, $urandom_range(1, 4));
      end
      ready_rand = 1'b1;
      model_run();
      drive_src();
      drive_ready();
      run("random", 600, n);
    end
    ready_rand = 1'b0;
    for (int k = 0; k < 3; k++) gap_len[k] = 0;

    // reset during beat 2 of a 4-beat TX packet
    do_reset();
    sb_en = 1'b0;
    add_pkt(1, 4);
    drive_src();
    drive_ready();
    n = 0;
    while (src_q[1].size() > 3 && n < 10) begin
      step();
      n++;
    end
    chk_int("rstmid_beat1_taken", src_q[1].size(), 3);
    rst = 1'b1;
    @(negedge clk);
    chk_int("rstmid_out_valid0", int'(o_valid), 0);
    chk_int("rstmid_src_ready0", int'(s_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_int("rstmid_out_valid1", int'(o_valid), 0);
    chk_int("rstmid_src_ready1", int'(s_ready), 0);
    @(posedge clk);
    #1;
    do_reset();
    sb_en = 1'b1;
    for (int k = 0; k < 3; k++) add_pkt(k, 1);
    model_run();
    drive_src();
    drive_ready();
    run("post_rst", 20, n);
    chk_int("post_rst_cycles", n, 3 + LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
